// File: rtl/id_stage.sv
// Instruction decode stage: splits a 36-bit instruction into opcode, register
// addresses and raw immediate, buffered by a two-entry skid register.
module id_stage #(
  parameter int INSTR_WIDTH    = 36,
  parameter int PC_WIDTH       = 16,
  parameter int OPCODE_WIDTH   = 6,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int SELECT_WIDTH   = 2,
  parameter int IMM_MAX_WIDTH  = 14
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [INSTR_WIDTH-1:0]    i_instr,
  input  logic [PC_WIDTH-1:0]       i_pc,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic                      i_flush,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [OPCODE_WIDTH-1:0]   o_opcode,
  output logic [REG_ADDR_WIDTH-1:0] o_rd,
  output logic [REG_ADDR_WIDTH-1:0] o_rs1,
  output logic [REG_ADDR_WIDTH-1:0] o_rs2,
  output logic [IMM_MAX_WIDTH-1:0]  o_immRaw,
  output logic [SELECT_WIDTH-1:0]   o_immSel,
  output logic [PC_WIDTH-1:0]       o_pc,
  output logic                      o_illegal
);

  localparam int RD_MSB  = INSTR_WIDTH - OPCODE_WIDTH - 1;
  localparam int RS1_MSB = RD_MSB - REG_ADDR_WIDTH;
  localparam int RS2_MSB = RS1_MSB - REG_ADDR_WIDTH;
  localparam int GAP_MSB = RS2_MSB - REG_ADDR_WIDTH;

  localparam logic [SELECT_WIDTH-1:0] SEL_NONE = 2'b00;
  localparam logic [SELECT_WIDTH-1:0] SEL_I    = 2'b01;
  localparam logic [SELECT_WIDTH-1:0] SEL_J    = 2'b10;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0]   opcode;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [IMM_MAX_WIDTH-1:0]  imm_raw;
    logic [SELECT_WIDTH-1:0]   imm_sel;
    logic [PC_WIDTH-1:0]       pc;
    logic                      illegal;
  } beat_t;

  state_t state, state_next;
  beat_t  out_q, skid_q, dec;
  logic   ready_q;
  logic   accept, emit;

  // Bits between rs2 and the J immediate carry no field.
  logic   unused_gap;
  assign unused_gap = ^i_instr[GAP_MSB:IMM_MAX_WIDTH];

  always_comb begin
    // NOTE: default every field first so no path leaves a latch behind.
    dec         = '0;
    dec.opcode  = i_instr[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    dec.rd      = i_instr[RD_MSB -: REG_ADDR_WIDTH];
    dec.rs1     = i_instr[RS1_MSB -: REG_ADDR_WIDTH];
    dec.rs2     = i_instr[RS2_MSB -: REG_ADDR_WIDTH];
    dec.pc      = i_pc;
    unique case (dec.opcode[OPCODE_WIDTH-1 -: 2])
      2'b00: dec.imm_sel = SEL_NONE;
      2'b01: begin
        dec.imm_sel = SEL_I;
        dec.imm_raw = IMM_MAX_WIDTH'(i_instr[7:0]);
      end
      2'b10: begin
        dec.imm_sel = SEL_J;
        dec.imm_raw = i_instr[IMM_MAX_WIDTH-1:0];
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign accept = i_valid && ready_q;
  assign emit   = (state != EMPTY) && i_ready;

  always_comb begin
    state_next = state;
    if (i_flush) begin
      state_next = EMPTY;
    end else begin
      unique case (state)
        EMPTY:   if (accept) state_next = ONE;
        ONE: begin
          if (accept && !emit)      state_next = TWO;
          else if (!accept && emit) state_next = EMPTY;
        end
        TWO:     if (emit) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; data registers are reset so outputs start at 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next != TWO);
      if (!i_flush) begin
        unique case (state)
          EMPTY: if (accept) out_q <= dec;
          ONE: begin
            if (accept && emit)  out_q  <= dec;
            if (accept && !emit) skid_q <= dec;
          end
          TWO:     if (emit) out_q <= skid_q;
          default: ;
        endcase
      end
    end
  end

  assign o_ready   = ready_q;
  assign o_valid   = (state != EMPTY);
  assign o_opcode  = out_q.opcode;
  assign o_rd      = out_q.rd;
  assign o_rs1     = out_q.rs1;
  assign o_rs2     = out_q.rs2;
  assign o_immRaw  = out_q.imm_raw;
  assign o_immSel  = out_q.imm_sel;
  assign o_pc      = out_q.pc;
  assign o_illegal = out_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode fields, skid buffering, flush and reset.
module tb_id_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [35:0] i_instr;
  logic [15:0] i_pc;
  logic        i_valid;
  logic        o_ready;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [5:0]  o_opcode;
  logic [3:0]  o_rd, o_rs1, o_rs2;
  logic [13:0] o_immRaw;
  logic [1:0]  o_immSel;
  logic [15:0] o_pc;
  logic        o_illegal;

  int tests = 0;
  int fails = 0;

  id_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_instr(i_instr), .i_pc(i_pc),
    .i_valid(i_valid), .o_ready(o_ready), .i_flush(i_flush),
    .o_valid(o_valid), .i_ready(i_ready), .o_opcode(o_opcode),
    .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_immRaw(o_immRaw),
    .o_immSel(o_immSel), .o_pc(o_pc), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [35:0] instr, input logic [15:0] pc);
    i_valid = v;
    i_instr = instr;
    i_pc    = pc;
  endtask

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_instr = '0; i_pc = '0;
    i_flush = 1'b0; i_ready = 1'b1;
    #12;
    check("rst_valid", 36'(o_valid), 36'd0);
    check("rst_ready", 36'(o_ready), 36'd1);
    check("rst_opcode", 36'(o_opcode), 36'd0);
    check("rst_immsel", 36'(o_immSel), 36'd0);
    check("rst_illegal", 36'(o_illegal), 36'd0);
    check("rst_pc", 36'(o_pc), 36'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();

    // R-type opcode 03, rd=1, rs1=2, rs2=2
    drive(1'b1, 36'h0C4880000, 16'h0100);
    tick();
    check("r_valid", 36'(o_valid), 36'd1);
    check("r_opcode", 36'(o_opcode), 36'h03);
    check("r_rd", 36'(o_rd), 36'd1);
    check("r_rs1", 36'(o_rs1), 36'd2);
    check("r_rs2", 36'(o_rs2), 36'd2);
    check("r_immsel", 36'(o_immSel), 36'd0);
    check("r_immraw", 36'(o_immRaw), 36'd0);
    check("r_pc", 36'(o_pc), 36'h0100);

    // I-type (imm byte A5, upper low bits must be masked) then J-type back-to-back
    drive(1'b1, {6'h10, 4'd3, 4'd4, 4'd5, 18'h3F0A5}, 16'h0104);
    tick();
    check("i_immsel", 36'(o_immSel), 36'd1);
    check("i_immraw", 36'(o_immRaw), 36'h00A5);
    check("i_rd", 36'(o_rd), 36'd3);
    drive(1'b1, {6'h21, 4'd6, 4'd7, 4'd8, 18'h0FFFF}, 16'h0108);
    tick();
    check("j_valid", 36'(o_valid), 36'd1);
    check("j_immsel", 36'(o_immSel), 36'd2);
    check("j_immraw", 36'(o_immRaw), 36'h3FFF);
    check("j_pc", 36'(o_pc), 36'h0108);
    drive(1'b0, '0, '0);
    tick();
    check("drain_valid", 36'(o_valid), 36'd0);

    // Backpressure stream A,B,C,D
    drive(1'b1, {6'h01, 30'd0}, 16'h0A00);
    tick();
    check("bp_a_out", 36'(o_pc), 36'h0A00);
    i_ready = 1'b0;
    drive(1'b1, {6'h02, 30'd0}, 16'h0B00);
    tick();
    check("bp_two_ready", 36'(o_ready), 36'd0);
    check("bp_hold_a", 36'(o_pc), 36'h0A00);
    drive(1'b1, {6'h03, 30'd0}, 16'h0C00);
    tick();
    check("bp_hold_a2", 36'(o_pc), 36'h0A00);
    check("bp_hold_op", 36'(o_opcode), 36'h01);
    check("bp_ready_low", 36'(o_ready), 36'd0);
    i_ready = 1'b1;
    tick();
    check("bp_b_out", 36'(o_pc), 36'h0B00);
    check("bp_b_op", 36'(o_opcode), 36'h02);
    check("bp_ready_up", 36'(o_ready), 36'd1);
    tick();
    check("bp_c_out", 36'(o_pc), 36'h0C00);
    drive(1'b1, {6'h04, 30'd0}, 16'h0D00);
    tick();
    check("bp_d_out", 36'(o_pc), 36'h0D00);
    check("bp_d_valid", 36'(o_valid), 36'd1);
    drive(1'b0, '0, '0);
    tick();
    check("bp_empty", 36'(o_valid), 36'd0);

    // Illegal class still flows
    drive(1'b1, {6'b110000, 12'd0, 18'h3FFFF}, 16'h0E00);
    tick();
    check("ill_valid", 36'(o_valid), 36'd1);
    check("ill_flag", 36'(o_illegal), 36'd1);
    check("ill_immsel", 36'(o_immSel), 36'd0);
    check("ill_immraw", 36'(o_immRaw), 36'd0);
    drive(1'b0, '0, '0);
    tick();
    check("ill_gone", 36'(o_valid), 36'd0);

    // Fill to TWO, then flush with an incoming beat
    i_ready = 1'b0;
    drive(1'b1, {6'h05, 30'd0}, 16'h0F00);
    tick();
    drive(1'b1, {6'h06, 30'd0}, 16'h0F04);
    tick();
    check("fl_two_ready", 36'(o_ready), 36'd0);
    i_flush = 1'b1;
    drive(1'b1, {6'h07, 30'd0}, 16'h0F08);
    i_ready = 1'b1;
    tick();
    check("fl_valid", 36'(o_valid), 36'd0);
    check("fl_ready", 36'(o_ready), 36'd1);
    i_flush = 1'b0;
    drive(1'b0, '0, '0);
    tick();
    check("fl_no_emit", 36'(o_valid), 36'd0);

    // Fill to TWO, then asynchronous reset between edges
    i_ready = 1'b0;
    drive(1'b1, {6'h08, 30'd0}, 16'h1000);
    tick();
    drive(1'b1, {6'h09, 30'd0}, 16'h1004);
    tick();
    check("ar_two_valid", 36'(o_valid), 36'd1);
    drive(1'b0, '0, '0);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("ar_valid", 36'(o_valid), 36'd0);
    check("ar_ready", 36'(o_ready), 36'd1);
    check("ar_pc", 36'(o_pc), 36'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    tick();
    check("ar_post_valid", 36'(o_valid), 36'd0);
    tick();
    check("ar_post_valid2", 36'(o_valid), 36'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
